// File: rtl/pixel_palette_mixer.sv
// Priority merge of layer colour codes, palette lookup and VGA output stage.
// CPU-visible palette and control share the playfield bus; sync/blank delayed to match colour.
module pixel_palette_mixer #(
  parameter int          NUM_LAYERS = 2,
  parameter int          CODE_W     = 2,
  parameter int          COLOR_W    = 8,
  parameter logic [15:0] PAL_BASE   = 16'h1400
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [15:0]                  addr,
  input  logic [7:0]                   data_in,
  input  logic                         we_l,
  output logic [7:0]                   data_out,
  input  logic [NUM_LAYERS*CODE_W-1:0] layer_code,
  input  logic                         hs_in,
  input  logic                         vs_in,
  input  logic                         blank_n_in,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic                         VGA_BLANK_N,
  output logic [COLOR_W-1:0]           VGA_R,
  output logic [COLOR_W-1:0]           VGA_G,
  output logic [COLOR_W-1:0]           VGA_B
);

  localparam int NCODE  = 1 << CODE_W;
  localparam int NENT   = NUM_LAYERS * NCODE;
  localparam int PIDX_W = $clog2(NENT);

  function automatic logic [COLOR_W-1:0] exp3(input logic [2:0] v);
    logic [COLOR_W-1:0] r;
    for (int i = 0; i < COLOR_W; i++) r[COLOR_W-1-i] = v[2-(i%3)];
    return r;
  endfunction

  function automatic logic [COLOR_W-1:0] exp2(input logic [1:0] v);
    logic [COLOR_W-1:0] r;
    for (int i = 0; i < COLOR_W; i++) r[COLOR_W-1-i] = v[1-(i%2)];
    return r;
  endfunction

  logic [7:0]                   pal_q [NENT];
  logic [7:0]                   pal_d [NENT];
  logic [1:0]                   ctrl_q, ctrl_d;
  logic [7:0]                   rd_q, rd_d;
  logic [NUM_LAYERS*CODE_W-1:0] code_q, code_d;
  logic                         hs1_q, hs1_d, vs1_q, vs1_d;
  logic                         bl1_q, bl1_d;
  logic                         hs2_q, hs2_d, vs2_q, vs2_d;
  logic                         bl2_q, bl2_d;
  logic [COLOR_W-1:0]           r_q, r_d, g_q, g_d, b_q, b_d;

  logic [15:0]       off;
  logic              in_win, is_ctrl;
  logic [PIDX_W-1:0] pidx, win;
  logic [CODE_W-1:0] c;
  logic              hit;
  logic [7:0]        pix;

  assign off     = addr - PAL_BASE;
  assign in_win  = (addr >= PAL_BASE) && (off <= 16'(NENT));
  assign is_ctrl = (off == 16'(NENT));
  assign pidx    = off[PIDX_W-1:0];

  // Walk layers bottom-up: normal mode keeps the last hit, REV keeps the first.
  always_comb begin
    win = '0;
    hit = 1'b0;
    c   = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      c = code_q[l*CODE_W +: CODE_W];
      if (c != '0 && (!ctrl_q[1] || !hit)) begin
        win = PIDX_W'(l * NCODE + int'(c));
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    pal_d  = pal_q;
    ctrl_d = ctrl_q;
    rd_d   = 8'h00;
    if (in_win) rd_d = is_ctrl ? {6'b0, ctrl_q} : pal_q[pidx];
    if (!we_l && in_win) begin
      if (is_ctrl) ctrl_d = data_in[1:0];
      else         pal_d[pidx] = data_in;
    end
  end

  always_comb begin
    code_d = layer_code;
    hs1_d  = hs_in;
    vs1_d  = vs_in;
    bl1_d  = blank_n_in;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    bl2_d  = bl1_q;
    pix    = pal_q[win];
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    if (bl1_q && ctrl_q[0]) begin
      r_d = exp3(pix[7:5]);
      g_d = exp3(pix[4:2]);
      b_d = exp2(pix[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NENT; i++) pal_q[i] <= 8'h00;
      ctrl_q <= 2'b01;
      rd_q   <= 8'h00;
      code_q <= '0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      bl1_q  <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      bl2_q  <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      pal_q  <= pal_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      code_q <= code_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      bl1_q  <= bl1_d;
      hs2_q  <= hs2_d;
      vs2_q  <= vs2_d;
      bl2_q  <= bl2_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign data_out    = rd_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_N = bl2_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_pixel_palette_mixer.sv
// Bench for pixel_palette_mixer: directed literal checks plus random
// stimulus against a cycle-level reference model.
module tb_pixel_palette_mixer;

  localparam int          NL   = 2;
  localparam int          NENT = 8;
  localparam logic [15:0] PB   = 16'h1400;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data_in = 8'h0;
  logic        we_l = 1'b1;
  logic [7:0]  data_out;
  logic [3:0]  layer_code = 4'h0;
  logic        hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b0;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int checks = 0;
  int failures = 0;

  pixel_palette_mixer dut (
    .clk(clk), .rst_l(rst_l), .addr(addr), .data_in(data_in),
    .we_l(we_l), .data_out(data_out), .layer_code(layer_code),
    .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: palette contents, control, and the last-seen pixel inputs
  logic [7:0] m_pal [NENT+1];
  logic [3:0] m_code;
  logic       m_hs, m_vs, m_bl, m_valid = 1'b0;
  logic [7:0] e_do, e_r, e_g, e_b;
  logic       e_hs, e_vs, e_bl;

  function automatic logic [7:0] x3(input logic [2:0] v);
    return 8'((int'(v) * 73) >> 1);
  endfunction

  function automatic logic [7:0] x2(input logic [1:0] v);
    return 8'(int'(v) * 85);
  endfunction

  function automatic int pick(input logic [3:0] codes, input logic rev);
    int w = -1;
    int cd;
    if (rev) begin
      for (int l = NL - 1; l >= 0; l--)
        if (int'(codes[l*2 +: 2]) != 0) w = l;
    end else begin
      for (int l = 0; l < NL; l++)
        if (int'(codes[l*2 +: 2]) != 0) w = l;
    end
    if (w < 0) return 0;
    cd = int'(codes[w*2 +: 2]);
    return w * 4 + cd;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    int ofs, w;
    logic [7:0] byt;
    logic on;
    if (!rst_l) begin
      for (int i = 0; i <= NENT; i++) m_pal[i] = 8'h00;
      m_pal[NENT] = 8'h01;
      m_code = 4'h0;
      m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b0;
      e_do = 8'h00; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      ofs = int'(addr) - int'(PB);
      e_do = (ofs >= 0 && ofs <= NENT) ? m_pal[ofs] : 8'h00;
      w = pick(m_code, m_pal[NENT][1]);
      byt = m_pal[w];
      on = m_bl && m_pal[NENT][0];
      e_r = on ? x3(byt[7:5]) : 8'h00;
      e_g = on ? x3(byt[4:2]) : 8'h00;
      e_b = on ? x2(byt[1:0]) : 8'h00;
      e_hs = m_hs; e_vs = m_vs; e_bl = m_bl;
      m_code = layer_code;
      m_hs = hs_in; m_vs = vs_in; m_bl = blank_n_in;
      if (!we_l && ofs >= 0 && ofs <= NENT)
        m_pal[ofs] = (ofs == NENT) ? (data_in & 8'h03) : data_in;
    end
    #1;
    if (m_valid) begin
      chk("m_do", 32'(data_out), 32'(e_do));
      chk("m_r", 32'(VGA_R), 32'(e_r));
      chk("m_g", 32'(VGA_G), 32'(e_g));
      chk("m_b", 32'(VGA_B), 32'(e_b));
      chk("m_hs", 32'(VGA_HS), 32'(e_hs));
      chk("m_vs", 32'(VGA_VS), 32'(e_vs));
      chk("m_bl", 32'(VGA_BLANK_N), 32'(e_bl));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; we_l = 1'b0;
    cyc(1);
    we_l = 1'b1;
  endtask

  task automatic rgb(input string nm, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b);
    chk({nm, "_r"}, 32'(VGA_R), 32'(r));
    chk({nm, "_g"}, 32'(VGA_G), 32'(g));
    chk({nm, "_b"}, 32'(VGA_B), 32'(b));
  endtask

  initial begin
    cyc(3);
    chk("rst_hs", 32'(VGA_HS), 32'h1);
    chk("rst_vs", 32'(VGA_VS), 32'h1);
    chk("rst_bl", 32'(VGA_BLANK_N), 32'h0);
    rgb("rst", 8'h00, 8'h00, 8'h00);
    chk("rst_do", 32'(data_out), 32'h0);
    rst_l = 1'b1;
    addr = PB + 16'd8;
    cyc(1);
    chk("ctrl_rst", 32'(data_out), 32'h01);

    wr(PB + 16'd7, 8'hE0);
    cyc(1);
    chk("rd_p7", 32'(data_out), 32'hE0);
    addr = PB + 16'd9;
    cyc(1);
    chk("rd_oow", 32'(data_out), 32'h00);

    wr(PB + 16'd2, 8'h1C);
    layer_code = 4'b1110;
    blank_n_in = 1'b1;
    cyc(2);
    rgb("l1win", 8'hFF, 8'h00, 8'h00);
    wr(PB + 16'd8, 8'h03);
    cyc(1);
    rgb("rev", 8'h00, 8'hFF, 8'h00);

    wr(PB + 16'd0, 8'h03);
    layer_code = 4'h0;
    cyc(2);
    rgb("bg", 8'h00, 8'h00, 8'hFF);
    blank_n_in = 1'b0;
    cyc(1);
    chk("blk1_bl", 32'(VGA_BLANK_N), 32'h1);
    chk("blk1_b", 32'(VGA_B), 32'hFF);
    cyc(1);
    chk("blk2_bl", 32'(VGA_BLANK_N), 32'h0);
    chk("blk2_b", 32'(VGA_B), 32'h00);

    hs_in = 1'b0; vs_in = 1'b0;
    cyc(1);
    chk("hs_d1", 32'(VGA_HS), 32'h1);
    hs_in = 1'b1;
    cyc(1);
    chk("hs_d2", 32'(VGA_HS), 32'h0);
    chk("vs_d2", 32'(VGA_VS), 32'h0);
    vs_in = 1'b1;
    cyc(1);
    chk("hs_d3", 32'(VGA_HS), 32'h1);

    blank_n_in = 1'b1;
    wr(PB + 16'd8, 8'h00);
    cyc(3);
    rgb("en0", 8'h00, 8'h00, 8'h00);
    wr(PB + 16'd8, 8'h01);
    cyc(2);
    rgb("en1", 8'h00, 8'h00, 8'hFF);

    wr(PB + 16'd1, 8'h5A);
    cyc(1);
    chk("p1_new", 32'(data_out), 32'h5A);
    addr = PB + 16'd1; data_in = 8'h33; we_l = 1'b0;
    cyc(1);
    chk("p1_old", 32'(data_out), 32'h5A);
    we_l = 1'b1;
    cyc(1);
    chk("p1_33", 32'(data_out), 32'h33);

    #2 rst_l = 1'b0;
    #1;
    chk("arst_bl", 32'(VGA_BLANK_N), 32'h0);
    chk("arst_hs", 32'(VGA_HS), 32'h1);
    chk("arst_do", 32'(data_out), 32'h0);
    rgb("arst", 8'h00, 8'h00, 8'h00);
    cyc(1);
    rst_l = 1'b1;
    cyc(1);
    chk("arst_p1", 32'(data_out), 32'h00);

    for (int i = 0; i < 3000; i++) begin
      layer_code = 4'($urandom);
      hs_in      = 1'($urandom);
      vs_in      = ($urandom_range(0, 7) != 0);
      blank_n_in = ($urandom_range(0, 3) != 0);
      addr       = PB - 16'd2 + 16'($urandom_range(0, 12));
      data_in    = 8'($urandom);
      we_l       = ($urandom_range(0, 9) > 2);
      if (addr == PB + 16'd8 && $urandom_range(0, 3) != 0)
        data_in[0] = 1'b1;
      cyc(1);
    end
    we_l = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
